ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Two-requester, round-robin arbiter and sequencer for the single-port 64 x 512-bit `RAM` block of the parallel adder accumulator. It sits between the RAM and its two clients, the operand loader (requester 0) and the accumulator writeback path (requester 1). It serialises their read and write requests onto the one RAM port, holds the address, write-enable and data stable for the whole access, and returns read data on a per-requester response strobe.

## Interface
Parameters:
- `ADDR_WIDTH`, default 6: RAM address width.
- `DATA_WIDTH`, default 512: RAM word width.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `req_valid`  in  2: bit i is the request valid for requester i.
- `req_ready`  out  2: bit i means requester i's request is accepted this cycle.
- `req_we`  in  2: bit i is 1 for a write, 0 for a read.
- `req0_addr`, `req1_addr`  in  ADDR_WIDTH: request address.
- `req0_wdata`, `req1_wdata`  in  DATA_WIDTH: write data.
- `rsp_valid`  out  2: one-cycle read-data strobe per requester.
- `rsp_rdata`  out  DATA_WIDTH: read data, qualified by `rsp_valid`.
- `busy`  out  1: high in any state other than IDLE.
- `ram_addr`  out  ADDR_WIDTH: to RAM `addr`.
- `ram_we`  out  1: to RAM `write_enable`.
- `ram_wdata`  out  DATA_WIDTH: to RAM `data_in`.
- `ram_rdata`  in  DATA_WIDTH: from RAM `data_out`.

## Operation
- **FSM states:** IDLE, ACCESS, CAPTURE.
  - IDLE -> ACCESS on any accepted request.
  - ACCESS -> IDLE for a write; ACCESS -> CAPTURE for a read.
  - CAPTURE -> IDLE always.
- **Arbitration (IDLE only):**
  - A lone valid requester wins.
  - If both are valid, the requester that is not `last_grant` wins.
  - `last_grant` resets to 1, so requester 0 wins the first tie.
  - `req_ready` is combinational from state, `req_valid` and `last_grant`. It is one-hot or zero, and zero outside IDLE.
- **Accept edge (IDLE with `req_ready` set):**
  - `ram_addr`, `ram_we` and `ram_wdata` are registered from the winner's inputs.
  - `owner` and `last_grant` are set to the winner.
- **ACCESS:**
  - The RAM inputs are held for the whole cycle.
  - A write commits at the edge ending ACCESS, and `ram_we` returns to 0 on that same edge.
- **CAPTURE:**
  - `ram_addr` is still held.
  - `rsp_rdata` is registered from `ram_rdata` at the edge ending CAPTURE.
  - `rsp_valid[owner]` is set for exactly the next cycle.
- **Outputs between accesses:**
  - `ram_addr` and `ram_wdata` keep their last values.
  - `rsp_rdata` keeps its last value until the next read completes.
- Writes produce no response.
- Requests that are not accepted must be held stable by the requester (valid/ready rule). The arbiter never drops or reorders an accepted request.

## Timing
- **Reset values:**
  - `req_ready` = 0, `rsp_valid` = 0, `rsp_rdata` = 0.
  - `busy` = 0, `ram_we` = 0, `ram_addr` = 0, `ram_wdata` = 0.
  - State = IDLE, `last_grant` = 1, `owner` = 0.
- **Write:** accept at cycle N, ACCESS at N+1, IDLE at N+2. Peak rate is one write per 2 cycles.
- **Read:** accept at cycle N, ACCESS at N+1, CAPTURE at N+2, `rsp_valid` at N+3 (which is also an IDLE cycle). Peak rate is one read per 3 cycles.
- A new request may be accepted in the same IDLE cycle that `rsp_valid` is high.
- **Simultaneous requests:** grants strictly alternate while both requesters stay valid. No requester waits more than one foreign transaction.
- **Address wrap:** none. Every address 0..63 is legal and passed through unchanged.
- **Reset mid-operation:**
  - The async assert forces `ram_we` to 0 and the state to IDLE immediately.
  - An in-flight read produces no `rsp_valid`.
  - An in-flight write may or may not have committed.

## Structure
- Package `ram_arb_pkg`:
  - State enum (IDLE = 2'd0, ACCESS = 2'd1, CAPTURE = 2'd2).
  - Default `ADDR_WIDTH` and `DATA_WIDTH` constants.
  - Requester index constants `REQ_LOADER` = 0 and `REQ_ACC` = 1.
- Sub-module `rr_arbiter2`: combinational 2-way round-robin grant from `req_valid`, `last_grant` and an enable (state == IDLE). Unit-testable on its own.
- The top level holds the FSM, RAM-side registers and response registers. It instantiates `RAM` only in the bench.

## Test plan
- **Reset then idle:** assert `rst_n` = 0 then release, no requests -> all outputs 0, `busy` = 0, `ram_we` never high.
- **Single write/read from requester 0:** write 0xaa to address 0, then read address 0 -> `rsp_valid[0]` exactly 3 cycles after the read accept, `rsp_rdata` = 0xaa, `rsp_valid[1]` stays 0.
- **Tie and alternation:** after reset, both requesters valid for four requests each (requester 0 writes 0x55 to address 1, requester 1 writes 0x2a to address 2, and so on) -> grant order 0,1,0,1,...; `ram_we` high for exactly one cycle per write.
- **Overwrite:** write 0x55 then 0x2a to address 1, then read it -> `rsp_rdata` = 0x2a.
- **Boundary address:** write a full 512-bit pattern (all ones with bit 0 cleared) to address 63, then read it back -> identical 512-bit value; address 0 is unaffected.
- **Reset during read:** assert `rst_n` low in CAPTURE -> no `rsp_valid`, state IDLE, and the next read after release completes normally.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared state encoding, default widths and requester indices for the RAM arbiter
package ram_arb_pkg;
  localparam int ADDR_WIDTH_DEF = 6;
  localparam int DATA_WIDTH_DEF = 512;
  localparam int REQ_LOADER = 0;
  localparam int REQ_ACC = 1;
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, CAPTURE = 2'd2} state_e;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant, favouring the requester that did not win last
module rr_arbiter2 (
  input  logic       en,
  input  logic [1:0] req_valid,
  input  logic       last_grant,
  output logic [1:0] grant
);
  always_comb grant = !en ? 2'b00 : &req_valid ? (last_grant ? 2'b01 : 2'b10) : req_valid;
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: serialises two requesters onto one single-port RAM and returns read data per requester
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0]            req_we,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic [1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);
  state_e state_q, state_d;
  logic last_grant_q, last_grant_d, owner_q, owner_d, ram_we_q, ram_we_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d, rsp_rdata_q, rsp_rdata_d;
  logic [1:0] rsp_valid_q, rsp_valid_d;
  logic accept, win;
  rr_arbiter2 u_arb (
    .en(state_q == IDLE),
    .req_valid(req_valid),
    .last_grant(last_grant_q),
    .grant(req_ready)
  );
  always_comb begin
    accept = |req_ready;
    win = req_ready[REQ_ACC];
    state_d = state_q == IDLE ? (accept ? ACCESS : IDLE) :
              state_q == ACCESS ? (ram_we_q ? IDLE : CAPTURE) : IDLE;
    last_grant_d = accept ? win : last_grant_q;
    owner_d = accept ? win : owner_q;
    ram_we_d = accept & req_we[win];
    ram_addr_d = accept ? (win ? req1_addr : req0_addr) : ram_addr_q;
    ram_wdata_d = accept ? (win ? req1_wdata : req0_wdata) : ram_wdata_q;
    rsp_valid_d = state_q == CAPTURE ? 2'b01 << owner_q : 2'b00;
    rsp_rdata_d = state_q == CAPTURE ? ram_rdata : rsp_rdata_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_grant_q <= 1'b1;
      owner_q <= 1'b0;
      ram_we_q <= 1'b0;
      ram_addr_q <= '0;
      ram_wdata_q <= '0;
      rsp_valid_q <= 2'b00;
      rsp_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_grant_q <= last_grant_d;
      owner_q <= owner_d;
      ram_we_q <= ram_we_d;
      ram_addr_q <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end
  assign busy = state_q != IDLE;
  assign ram_addr = ram_addr_q;
  assign ram_we = ram_we_q;
  assign ram_wdata = ram_wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: table vectors, directed corner sequences and random traffic against a transaction-level model
module tb_ram_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] req_valid, req_ready, req_we, rsp_valid;
  logic [5:0] req0_addr, req1_addr, ram_addr;
  logic [511:0] req0_wdata, req1_wdata, rsp_rdata, ram_wdata, ram_rdata;
  logic busy, ram_we;

  ram_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req0_addr(req0_addr), .req1_addr(req1_addr), .req0_wdata(req0_wdata), .req1_wdata(req1_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy), .ram_addr(ram_addr),
    .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // behavioural single-port RAM with registered read
  logic [511:0] ram_mem [64];
  logic ram_init = 1'b0;
  always @(posedge clk) begin
    if (!ram_init) begin
      foreach (ram_mem[i]) ram_mem[i] <= '0;
      ram_init <= 1'b1;
    end else begin
      if (ram_we) ram_mem[ram_addr] <= ram_wdata;
      ram_rdata <= ram_mem[ram_addr];
    end
  end

  int tests = 0, fails = 0;

  task automatic chk(input string n, input logic [511:0] a, input logic [511:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic chki(input string n, input int a, input int e);
    tests++;
    if (a != e) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask

  // transaction-level model: each accepted op occupies the port for 2 (write) or 3 (read) cycles
  int cyc = 0, m_free = 0, m_rsp_at = -1, m_we_at = -1;
  bit m_last = 1'b1, m_rsp_who;
  logic [511:0] m_mem [64] = '{default: '0};
  logic [511:0] m_rsp_data, m_wdata = '0, m_rdata = '0;
  logic [5:0] m_addr = '0;
  int n_rsp = 0, n_we = 0;
  bit obs_who;
  logic [511:0] obs_data;

  always @(negedge clk) begin
    logic [1:0] er, ev;
    bit w;
    if (!rst_n) begin
      m_free = cyc; m_last = 1'b1; m_rsp_at = -1; m_we_at = -1;
      m_addr = '0; m_wdata = '0; m_rdata = '0;
      chki("rst_ready", int'(req_ready), 0);
      chki("rst_rsp_valid", int'(rsp_valid), 0);
      chki("rst_busy", int'(busy), 0);
      chki("rst_ram_we", int'(ram_we), 0);
      chki("rst_ram_addr", int'(ram_addr), 0);
      chk("rst_ram_wdata", ram_wdata, '0);
      chk("rst_rsp_rdata", rsp_rdata, '0);
    end else begin
      er = 2'b00;
      if (cyc >= m_free && req_valid != 2'b00) begin
        w = (req_valid == 2'b11) ? !m_last : req_valid[1];
        er[w] = 1'b1;
      end
      ev = 2'b00;
      if (m_rsp_at == cyc) begin
        ev[m_rsp_who] = 1'b1;
        m_rdata = m_rsp_data;
      end
      chki("ready", int'(req_ready), int'(er));
      chki("busy", int'(busy), int'(cyc < m_free));
      chki("rsp_valid", int'(rsp_valid), int'(ev));
      chk("rsp_rdata", rsp_rdata, m_rdata);
      chki("ram_we", int'(ram_we), int'(m_we_at == cyc));
      chki("ram_addr", int'(ram_addr), int'(m_addr));
      chk("ram_wdata", ram_wdata, m_wdata);
      if (er != 2'b00) begin
        w = er[1];
        m_last = w;
        m_addr = w ? req1_addr : req0_addr;
        m_wdata = w ? req1_wdata : req0_wdata;
        if (req_we[w]) begin
          m_mem[m_addr] = m_wdata;
          m_we_at = cyc + 1;
          m_free = cyc + 2;
        end else begin
          m_rsp_at = cyc + 3;
          m_rsp_who = w;
          m_rsp_data = m_mem[m_addr];
          m_free = cyc + 3;
        end
      end
      if (rsp_valid != 2'b00) begin
        n_rsp++;
        obs_who = rsp_valid[1];
        obs_data = rsp_rdata;
      end
      if (ram_we) n_we++;
    end
    cyc++;
  end

  typedef struct {
    bit we;
    logic [5:0] addr;
    logic [511:0] wdata;
  } req_t;
  req_t q0[$], q1[$];
  int grants[$];

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // requesters hold each request until accepted; gaps only before a request is first presented
  task automatic run(input int max_cyc, input bit gaps);
    int n = 0;
    logic [1:0] fire;
    logic [1:0] held = 2'b00;
    while ((q0.size() != 0 || q1.size() != 0) && n < max_cyc) begin
      req_valid[0] = (q0.size() != 0) && (held[0] || !gaps || $urandom_range(3) != 0);
      req_valid[1] = (q1.size() != 0) && (held[1] || !gaps || $urandom_range(3) != 0);
      if (req_valid[0]) begin req_we[0] = q0[0].we; req0_addr = q0[0].addr; req0_wdata = q0[0].wdata; end
      if (req_valid[1]) begin req_we[1] = q1[0].we; req1_addr = q1[0].addr; req1_wdata = q1[0].wdata; end
      held = req_valid;
      @(negedge clk);
      fire = req_valid & req_ready;
      @(posedge clk);
      #1;
      if (fire[0]) begin void'(q0.pop_front()); grants.push_back(0); held[0] = 1'b0; end
      if (fire[1]) begin void'(q1.pop_front()); grants.push_back(1); held[1] = 1'b0; end
      n++;
    end
    req_valid = 2'b00;
    chki("drain", q0.size() + q1.size(), 0);
  endtask

  task automatic push(input bit who, input bit we, input logic [5:0] addr, input logic [511:0] wdata);
    req_t r;
    r.we = we; r.addr = addr; r.wdata = wdata;
    if (who) q1.push_back(r); else q0.push_back(r);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(2);
  endtask

  typedef struct {
    bit who;
    bit we;
    logic [5:0] addr;
    logic [511:0] wdata;
    logic [511:0] exp;
  } vec_t;
  vec_t tv[9];

  initial begin
    logic [511:0] pat;
    int c0, w0, nr;
    pat = '1;
    pat[0] = 1'b0;
    tv[0] = '{0, 1, 6'd0,  512'haa, '0};
    tv[1] = '{0, 0, 6'd0,  '0,      512'haa};
    tv[2] = '{1, 1, 6'd1,  512'h55, '0};
    tv[3] = '{0, 1, 6'd1,  512'h2a, '0};
    tv[4] = '{1, 0, 6'd1,  '0,      512'h2a};
    tv[5] = '{0, 1, 6'd63, pat,     '0};
    tv[6] = '{1, 0, 6'd63, '1,      pat};
    tv[7] = '{0, 0, 6'd0,  '0,      512'haa};
    tv[8] = '{1, 0, 6'd2,  '0,      '0};
    req_valid = 2'b00; req_we = 2'b00; req0_addr = '0; req1_addr = '0;
    req0_wdata = '0; req1_wdata = '0;
    rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    w0 = n_we;
    idle(4);
    chki("idle_no_we", n_we - w0, 0);

    foreach (tv[i]) begin
      c0 = n_rsp;
      push(tv[i].who, tv[i].we, tv[i].addr, tv[i].wdata);
      run(20, 1'b0);
      idle(4);
      chki("tv_rsp_count", n_rsp - c0, tv[i].we ? 0 : 1);
      if (!tv[i].we) begin
        chki("tv_rsp_who", int'(obs_who), int'(tv[i].who));
        chk("tv_rdata", obs_data, tv[i].exp);
      end
    end

    do_reset();
    grants.delete();
    w0 = n_we;
    for (int k = 0; k < 4; k++) begin
      push(0, 1, 6'(1 + 2 * k), 512'(8'h55 + k));
      push(1, 1, 6'(2 + 2 * k), 512'(8'h2a + k));
    end
    run(60, 1'b0);
    idle(3);
    chki("tie_count", grants.size(), 8);
    foreach (grants[i]) chki("tie_order", grants[i], i % 2);
    chki("tie_we_cycles", n_we - w0, 8);

    req_we = 2'b00; req0_addr = 6'd0; req_valid = 2'b01;
    @(negedge clk);
    chki("rr_ready", int'(req_ready), 1);
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    idle(1);
    chki("rr_busy_capture", int'(busy), 1);
    c0 = n_rsp;
    rst_n = 1'b0;
    #1;
    chki("rr_busy_async", int'(busy), 0);
    chki("rr_we_async", int'(ram_we), 0);
    idle(3);
    rst_n = 1'b1;
    idle(4);
    chki("rr_no_rsp", n_rsp - c0, 0);
    c0 = n_rsp;
    push(0, 0, 6'd0, '0);
    run(20, 1'b0);
    idle(4);
    chki("rr_after_count", n_rsp - c0, 1);
    chk("rr_after_rdata", obs_data, 512'haa);

    nr = 0;
    c0 = n_rsp;
    for (int i = 0; i < 80; i++) begin
      req_t r;
      r.we = 1'($urandom_range(1));
      r.addr = ($urandom_range(7) == 0) ? 6'd63 : 6'($urandom_range(7));
      for (int k = 0; k < 16; k++) r.wdata[k*32 +: 32] = $urandom;
      if (!r.we) nr++;
      if ($urandom_range(1) == 1) q1.push_back(r); else q0.push_back(r);
    end
    run(3000, 1'b1);
    idle(5);
    chki("rand_rsp_count", n_rsp - c0, nr);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
